// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for a max-period Galois-style LFSR pattern stream.
//   Hunts for the sequence, verifies LOCK_COUNT consecutive predictions,
//   then flywheels a local LFSR and flags every mismatching beat.
//
// Parameters
//   WIDTH          sequence width, 4..32
//   LOCK_COUNT     consecutive correct predictions needed to lock (>=1)
//   LOSS_COUNT     consecutive misses while locked that drop lock (>=1)
//   ERR_CNT_WIDTH  width of the saturating error counter
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   in_data_i carries a beat this cycle
//   in_data_i    received sequence value
//   clear_err_i  synchronous clear of err_count_o
//   locked_o     checker is locked (registered)
//   err_pulse_o  one-cycle pulse per mismatching beat while locked
//   err_count_o  saturating mismatch count while locked
module lfsr_checker #(
  parameter int WIDTH         = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int LOSS_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     clear_err_i,
  output logic                     locked_o,
  output logic                     err_pulse_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  function automatic logic [31:0] poly_for(input int w);
    case (w)
      4:  return 32'h0000000c;
      5:  return 32'h0000001b;
      6:  return 32'h00000033;
      7:  return 32'h00000065;
      8:  return 32'h000000c3;
      9:  return 32'h00000167;
      10: return 32'h00000309;
      11: return 32'h000004ec;
      12: return 32'h00000ac9;
      13: return 32'h0000124d;
      14: return 32'h00002367;
      15: return 32'h000042f9;
      16: return 32'h0000847d;
      17: return 32'h000101f5;
      18: return 32'h000202c9;
      19: return 32'h000402fa;
      20: return 32'h000805c1;
      21: return 32'h001003cb;
      22: return 32'h0020029f;
      23: return 32'h004003da;
      24: return 32'h00800a23;
      25: return 32'h010001a5;
      26: return 32'h02000155;
      27: return 32'h04000227;
      28: return 32'h080007db;
      29: return 32'h100004f3;
      30: return 32'h200003ab;
      31: return 32'h40000169;
      32: return 32'h800007c3;
      default: return 32'h00000000;
    endcase
  endfunction

  localparam logic [31:0]      POLY32 = poly_for(WIDTH);
  localparam logic [WIDTH-1:0] POLY   = POLY32[WIDTH-1:0];

  // Unsupported widths have no polynomial; refuse to elaborate.
  generate
    if (POLY32 == 32'h0) begin : g_bad_poly
      $fatal(1, "Illegal polynomial selected");
    end
  endgenerate

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_COUNT);

  // The inverted MSB feedback makes all-zero a sequence member.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    t = x ^ ({WIDTH{x[WIDTH-1]}} & POLY);
    return {t[WIDTH-2:0], ~x[WIDTH-1]};
  endfunction

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         pred_q, pred_d;
  logic [MW-1:0]            match_q, match_d, match_inc;
  logic [LW-1:0]            miss_q, miss_d, miss_inc;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                     locked_q, err_pulse_q;
  logic                     err_hit;

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_hit     = 1'b0;
    match_inc   = match_q + 1'b1;
    miss_inc    = miss_q + 1'b1;

    if (in_valid_i) begin
      case (state_q)
        ST_HUNT: begin
          pred_d  = lfsr_next(in_data_i);
          match_d = '0;
          state_d = ST_VERIFY;
        end
        ST_VERIFY: begin
          // Either way the next prediction follows the received data.
          pred_d = lfsr_next(in_data_i);
          if (in_data_i == pred_q) begin
            match_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: never reseed from data once locked.
          pred_d = lfsr_next(pred_q);
          if (in_data_i == pred_q) begin
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            miss_d  = miss_inc;
            if (miss_inc == LOSS_TGT) begin
              state_d = ST_HUNT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // Clear wins over accumulated count, but a same-cycle error still counts.
    err_count_d = err_count_q;
    if (clear_err_i) begin
      err_count_d = ERR_CNT_WIDTH'(err_hit);
    end else if (err_hit && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HUNT;
      pred_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_count_q <= err_count_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_hit;
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

endmodule
